ahb_arbiter: RTL

Round-robin AHB bus arbiter that shares the slave port (SRAM and other slaves behind the decoder) between up to NUM_MASTERS bus masters. It samples bus requests, burst type and transfer state, holds ownership for the full length of fixed-length bursts and undefined-length INCR bursts, and parks the bus on a default master when idle. It sits between the master-side request lines and the address/control multiplexer, and drives the HGRANT vector and the HMASTER select.

---
 rtl/ahb_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ahb_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ahb_arbiter : round-robin AHB arbiter, holds bursts, parks on DEFAULT_MASTER.
// Optional locked-transfer support via macro AHB_ARB_LOCK_EN.      Rev 1.0
// -----------------------------------------------------------------------------
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [3:0]             HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] TR_IDLE    = 2'b00;
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] TR_SEQ     = 2'b11;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [2:0] BURST_INCR = 3'b001;
  localparam logic [NUM_MASTERS-1:0] GRANT_RST =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_BURST = 2'd1,
    ST_INCR  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [3:0]             hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;
  logic                   err_pend_q, err_pend_d;

  logic [3:0]             owner_idx;
  logic                   owner_req;
  logic                   owner_lock;
  logic [3:0]             winner;
  logic                   win_found;
  logic [NUM_MASTERS-1:0] win_grant;
  logic [3:0]             burst_cnt;
  logic                   rearb;

`ifdef AHB_ARB_LOCK_EN
  assign owner_lock = |(HLOCK & grant_q);
`else
  logic unused_hlock;
  assign owner_lock  = 1'b0;
  assign unused_hlock = ^HLOCK;
`endif

  // Round-robin search starts one past the owner; offset NUM_MASTERS is the owner itself.
  always_comb begin
    owner_idx = 4'd0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) owner_idx = 4'(i);
    end
    owner_req = |(HBUSREQ & grant_q);
    winner    = 4'(DEFAULT_MASTER);
    win_found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!win_found && HBUSREQ[j] && ((int'(owner_idx) + k) % NUM_MASTERS) == j) begin
          win_found = 1'b1;
          winner    = 4'(j);
        end
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      win_grant[i] = (winner == 4'(i));
    end
    case (HBURST[2:1])
      2'b01:   burst_cnt = 4'd3;
      2'b10:   burst_cnt = 4'd7;
      2'b11:   burst_cnt = 4'd15;
      default: burst_cnt = 4'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    err_pend_d  = err_pend_q;
    rearb       = 1'b0;

    // An ERROR acts even in a wait state; the hand-over waits for HREADY.
    if (HRESP == RESP_ERROR) begin
      state_d = ST_ARB;
      cnt_d   = 4'd0;
      if (HREADY) begin
        rearb      = 1'b1;
        err_pend_d = 1'b0;
      end else begin
        err_pend_d = 1'b1;
      end
    end else if (HREADY) begin
      if (err_pend_q) begin
        rearb      = 1'b1;
        err_pend_d = 1'b0;
      end else begin
        case (state_q)
          ST_ARB: begin
            if (HTRANS == TR_NONSEQ && burst_cnt != 4'd0) begin
              state_d = ST_BURST;
              cnt_d   = burst_cnt;
            end else if (HTRANS == TR_NONSEQ && HBURST == BURST_INCR) begin
              state_d = ST_INCR;
            end else begin
              rearb = 1'b1;
            end
          end
          ST_BURST: begin
            if (HTRANS == TR_SEQ) begin
              if (cnt_q <= 4'd1) begin
                rearb   = 1'b1;
                state_d = ST_ARB;
                cnt_d   = 4'd0;
              end else begin
                cnt_d = cnt_q - 4'd1;
              end
            end else if (HTRANS == TR_IDLE || HTRANS == TR_NONSEQ) begin
              rearb   = 1'b1;
              state_d = ST_ARB;
              cnt_d   = 4'd0;
            end
          end
          ST_INCR: begin
            if (!owner_req) begin
              rearb   = 1'b1;
              state_d = ST_ARB;
            end
          end
          default: state_d = ST_ARB;
        endcase
      end
    end

    if (HREADY) begin
      hmaster_d   = owner_idx;
      hmastlock_d = owner_lock;
    end
    if (rearb && !owner_lock) grant_d = win_grant;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_ARB;
      cnt_q       <= 4'd0;
      grant_q     <= GRANT_RST;
      hmaster_q   <= 4'(DEFAULT_MASTER);
      hmastlock_q <= 1'b0;
      err_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      err_pend_q  <= err_pend_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

endmodule
`default_nettype wire
